// File: rtl/miner_pkg.sv
// Shared widths, FSM state encoding and the job/result records used by the
// miner work controller and its comparator.
package miner_pkg;
   localparam int HDR_W   = 608;
   localparam int HASH_W  = 256;
   localparam int NONCE_W = 32;

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CHECK, REPORT} state_t;

   // Hash-domain vectors are [0:W-1] so bit 0 is the MSB, as on the hasher side.
   typedef struct packed {
      logic [0:HDR_W-1]   header;
      logic [0:HASH_W-1]  target;
      logic [NONCE_W-1:0] nend;
   } job_t;

   typedef struct packed {
      logic               found;
      logic               err;
      logic [NONCE_W-1:0] nonce;
      logic [0:HASH_W-1]  hash;
      logic [NONCE_W-1:0] count;
   } result_t;
endpackage

// File: rtl/miner_target_compare.sv
// Unsigned hash <= target test; bit 0 is the most significant bit.
module miner_target_compare
   import miner_pkg::*;
(
   input  logic [0:HASH_W-1] i_hash,
   input  logic [0:HASH_W-1] i_target,
   output logic              o_le
);
   assign o_le = (i_hash <= i_target);
endmodule

// File: rtl/miner_work_controller.sv
// Sweeps a nonce range through the hasher, one run at a time, and reports the
// first hit, exhaustion, timeout or echo error on a valid/ready result port.
module miner_work_controller
   import miner_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_job_valid,
   output logic               o_job_ready,
   input  logic [0:HDR_W-1]   i_job_header,
   input  logic [0:HASH_W-1]  i_job_target,
   input  logic [NONCE_W-1:0] i_job_nstart,
   input  logic [NONCE_W-1:0] i_job_nend,
   input  logic               i_abort,
   output logic               o_hash_enable,
   output logic [0:HDR_W-1]   o_block,
   output logic [0:HASH_W-1]  o_target,
   output logic [NONCE_W-1:0] o_nonce,
   input  logic               i_finished,
   input  logic [0:HASH_W-1]  i_correct_hash,
   input  logic [NONCE_W-1:0] i_correct_nonce,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic               o_res_found,
   output logic               o_res_err,
   output logic [NONCE_W-1:0] o_res_nonce,
   output logic [0:HASH_W-1]  o_res_hash,
   output logic [NONCE_W-1:0] o_res_count,
   output logic               o_busy
);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   state_t             r_state, w_next;
   job_t               r_job;
   result_t            r_res, w_res;
   logic               r_live, w_accept, w_load, w_hit;
   logic [NONCE_W-1:0] r_nonce_q, r_count, r_echo;
   logic [0:HASH_W-1]  r_hash;
   logic [TW-1:0]      r_timer;

   miner_target_compare u_cmp (
      .i_hash   (r_hash),
      .i_target (r_job.target),
      .o_le     (w_hit)
   );

   // r_live keeps job_ready low while reset is asserted and until the first clock after.
   assign w_accept = (r_state == IDLE) && r_live && i_job_valid;

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_res      = '0;
      w_res.nonce = r_nonce_q;
      w_res.count = r_count;
      case (r_state)
         IDLE: if (w_accept) begin
            if (i_job_nstart > i_job_nend) begin
               w_next      = REPORT;
               w_load      = 1'b1;
               w_res.nonce = i_job_nstart;
               w_res.count = '0;
            end else begin
               w_next = LAUNCH;
            end
         end
         LAUNCH: w_next = WAIT;
         WAIT: begin
            if (i_finished) begin
               w_next = CHECK;
            end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
               w_next    = REPORT;
               w_load    = 1'b1;
               w_res.err = 1'b1;
            end
         end
         CHECK: begin
            w_res.count = r_count + 1'b1;
            w_next      = REPORT;
            w_load      = 1'b1;
            if (r_echo != r_nonce_q) begin
               w_res.err = 1'b1;
            end else if (w_hit) begin
               w_res.found = 1'b1;
               w_res.hash  = r_hash;
            end else if (r_nonce_q == r_job.nend) begin
               w_res.hash = r_hash;
            end else begin
               // end-of-range test precedes the increment, so no wrap at all-ones
               w_next = LAUNCH;
               w_load = 1'b0;
            end
         end
         REPORT: if (i_res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (i_abort && (r_state != IDLE)) begin
         w_next = IDLE;
         w_load = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_live    <= 1'b0;
         r_job     <= '0;
         r_res     <= '0;
         r_nonce_q <= '0;
         r_count   <= '0;
         r_echo    <= '0;
         r_hash    <= '0;
         r_timer   <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_job.header <= i_job_header;
            r_job.target <= i_job_target;
            r_job.nend   <= i_job_nend;
            r_nonce_q    <= i_job_nstart;
            r_count      <= '0;
         end
         if (r_state == LAUNCH)    r_timer <= '0;
         else if (r_state == WAIT) r_timer <= r_timer + 1'b1;
         if ((r_state == WAIT) && i_finished) begin
            r_hash <= i_correct_hash;
            r_echo <= i_correct_nonce;
         end
         if (r_state == CHECK) begin
            r_count <= w_res.count;
            if (w_next == LAUNCH) r_nonce_q <= r_nonce_q + 1'b1;
         end
         if (w_load) r_res <= w_res;
      end
   end

   assign o_job_ready   = r_live && (r_state == IDLE);
   assign o_busy        = (r_state != IDLE);
   assign o_hash_enable = (r_state == LAUNCH);
   assign o_res_valid   = (r_state == REPORT);
   assign o_block       = r_job.header;
   assign o_target      = r_job.target;
   assign o_nonce       = r_nonce_q;
   assign o_res_found   = r_res.found;
   assign o_res_err     = r_res.err;
   assign o_res_nonce   = r_res.nonce;
   assign o_res_hash    = r_res.hash;
   assign o_res_count   = r_res.count;
endmodule

// File: tb/tb_miner_work_controller.sv
// Scoreboard bench: behavioural hasher, range-sweep reference model, and a
// monitor that checks each result at its handshake.
module tb_miner_work_controller;
   import miner_pkg::*;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst, job_valid, job_ready, abort, hash_enable, finished;
   logic res_valid, res_ready, res_found, res_err, busy;
   logic [0:HDR_W-1]   job_header, block;
   logic [0:HASH_W-1]  job_target, target, correct_hash, res_hash;
   logic [NONCE_W-1:0] job_nstart, job_nend, nonce, correct_nonce, res_nonce, res_count;

   always #5 clk = ~clk;

   miner_work_controller #(.TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_job_valid(job_valid), .o_job_ready(job_ready),
      .i_job_header(job_header), .i_job_target(job_target),
      .i_job_nstart(job_nstart), .i_job_nend(job_nend), .i_abort(abort),
      .o_hash_enable(hash_enable), .o_block(block), .o_target(target), .o_nonce(nonce),
      .i_finished(finished), .i_correct_hash(correct_hash), .i_correct_nonce(correct_nonce),
      .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_found(res_found),
      .o_res_err(res_err), .o_res_nonce(res_nonce), .o_res_hash(res_hash),
      .o_res_count(res_count), .o_busy(busy)
   );

   typedef struct {
      logic        found, err;
      logic [31:0] nonce, count;
      logic [0:255] hash;
      bit          chk_nonce, chk_hash;
      int          pulses, lat;
   } exp_t;

   exp_t sb_q[$];
   int total = 0, bad = 0;

   // hasher model configuration
   int          hs_mode = 0, hs_never = 0, hs_lat_fix = 0;
   logic [31:0] hs_echo = 0, hit_n = 0, salt = 0;
   bit          hold_low = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [0:255] hash_of(input logic [31:0] n);
      logic [0:255] h;
      if (hs_mode == 0) h = (n == hit_n) ? 256'd1 : {256{1'b1}};
      else              h = {(n * 32'h9E37_79B1) ^ salt, n, {6{32'h1357_9bdf}}};
      return h;
   endfunction

   // What a sweep over [s,e] must report, from the rules alone.
   function automatic exp_t model(input logic [31:0] s, input logic [31:0] e, input logic [0:255] tgt);
      exp_t r;
      r.found = 0; r.err = 0; r.nonce = s; r.count = 0; r.hash = '0;
      r.chk_nonce = 1; r.chk_hash = 0; r.pulses = 0; r.lat = -1;
      if (s > e) begin r.chk_nonce = 0; return r; end
      if (hs_never != 0) begin r.err = 1; r.pulses = 1; r.lat = TO + 1; return r; end
      for (longint n = s; n <= e; n++) begin
         r.count++; r.pulses++; r.nonce = n[31:0];
         if (hs_echo != 0) return r_err(r);
         if (hash_of(n[31:0]) <= tgt) begin
            r.found = 1; r.hash = hash_of(n[31:0]); r.chk_hash = 1; return r;
         end
      end
      r.hash = hash_of(e); r.chk_hash = 1;
      return r;
   endfunction

   function automatic exp_t r_err(input exp_t r);
      exp_t q = r;
      q.err = 1;
      return q;
   endfunction

   // behavioural hasher: answers each launch after a short latency
   logic [31:0] hn;
   int          hlat;
   initial begin
      finished = 0; correct_hash = '0; correct_nonce = '0;
      forever begin
         @(posedge clk); #1;
         if (hash_enable && !rst && hs_never == 0) begin
            hn   = nonce;
            hlat = (hs_lat_fix > 0) ? hs_lat_fix : int'($urandom_range(1, 4));
            repeat (hlat) @(posedge clk);
            #1; finished = 1; correct_hash = hash_of(hn); correct_nonce = hn + hs_echo;
            @(posedge clk); #1; finished = 0;
         end
      end
   end

   initial begin
      res_ready = 0;
      forever begin
         @(posedge clk); #3;
         res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // monitor
   int   cyc = 0, pulses = 0, last_pulse = 0, acc_cyc = 0;
   bit   first_pulse = 0, prev_rv = 0, held = 0;
   logic [65:0]  snap;
   logic [0:255] snap_h;
   exp_t e;
   initial begin
      forever begin
         @(negedge clk); cyc++;
         if (rst) begin prev_rv = 0; held = 0; continue; end
         if (job_valid && job_ready) begin pulses = 0; acc_cyc = cyc; first_pulse = 1; end
         if (hash_enable) begin
            pulses++; last_pulse = cyc;
            if (first_pulse) begin check("launch_lat", cyc - acc_cyc, 1); first_pulse = 0; end
         end
         if (res_valid && !prev_rv && sb_q.size() > 0 && sb_q[0].lat >= 0)
            check("timeout_lat", cyc - last_pulse, sb_q[0].lat);
         if (res_valid && held) begin
            check("hold_fields", {res_found, res_err, res_nonce, res_count}, snap);
            check("hold_hash", res_hash, snap_h);
         end
         held = res_valid && !res_ready;
         if (held) begin snap = {res_found, res_err, res_nonce, res_count}; snap_h = res_hash; end
         if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_result: got nonce %0h, nothing expected", res_nonce);
            end else begin
               e = sb_q.pop_front();
               check("found", res_found, e.found);
               check("err", res_err, e.err);
               check("count", res_count, e.count);
               check("pulses", pulses, e.pulses);
               if (e.chk_nonce) check("nonce", res_nonce, e.nonce);
               if (e.chk_hash)  check("hash", res_hash, e.hash);
            end
         end
         prev_rv = res_valid;
      end
   end

   task automatic issue(input logic [31:0] s, input logic [31:0] en, input logic [0:255] tgt, input bit push);
      int k = 0;
      if (push) sb_q.push_back(model(s, en, tgt));
      @(posedge clk); #2;
      while (!job_ready && k < 200) begin @(posedge clk); #2; k++; end
      if (k >= 200) begin total++; bad++; $display("FAIL job_ready_wait: got 0 expected 1"); end
      job_header = {19{$urandom}}; job_target = tgt; job_nstart = s; job_nend = en; job_valid = 1;
      @(posedge clk); #2; job_valid = 0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while ((busy || sb_q.size() != 0) && k < 3000) begin @(posedge clk); #2; k++; end
      if (k >= 3000) begin total++; bad++; $display("FAIL %s_done: timed out, pending %0d", name, sb_q.size()); end
      sb_q.delete();
   endtask

   task automatic wait_rv();
      int k = 0;
      while (!res_valid && k < 500) begin @(posedge clk); #2; k++; end
      if (k >= 500) begin total++; bad++; $display("FAIL res_valid_wait: got 0 expected 1"); end
   endtask

   logic [0:255] tgt_lo, tgt;
   logic [31:0]  s, en;
   int           len, kk;
   bit           seen;
   initial begin
      rst = 1; job_valid = 0; abort = 0;
      job_header = '0; job_target = '0; job_nstart = '0; job_nend = '0;
      tgt_lo = {1'b0, {255{1'b1}}};
      repeat (3) @(posedge clk); #2;
      check("rst_ready", job_ready, 0);
      rst = 0; #1;
      check("ready_before_clk", job_ready, 0);
      @(posedge clk); #1;
      check("ready_after_clk", job_ready, 1);

      hs_mode = 0; hit_n = 32'h9546a142;
      issue(32'h9546a13f, 32'h9546a145, tgt_lo, 1); wait_done("hit");
      hit_n = 32'hdeadbeef;
      issue(0, 3, tgt_lo, 1);                    wait_done("exhaust");
      issue(5, 2, tgt_lo, 1);                    wait_done("empty");
      issue(32'hfffffffe, 32'hffffffff, tgt_lo, 1); wait_done("top");

      hs_never = 1; issue(32'h100, 32'h108, tgt_lo, 1); wait_done("timeout"); hs_never = 0;
      hs_echo = 1;  issue(32'h200, 32'h204, tgt_lo, 1); wait_done("echo");    hs_echo = 0;

      hold_low = 1; hit_n = 32'h302;
      issue(32'h300, 32'h305, tgt_lo, 1); wait_rv();
      repeat (10) @(posedge clk); #2; hold_low = 0;
      wait_done("hold");

      // abort in WAIT on the very cycle the hasher finishes
      hs_lat_fix = 3;
      issue(32'h400, 32'h410, tgt_lo, 0);
      kk = 0;
      while (!finished && kk < 100) begin @(negedge clk); kk++; end
      check("abort_saw_finished", finished, 1);
      abort = 1; @(posedge clk); #1; abort = 0;
      check("abort_busy", busy, 0);
      check("abort_ready", job_ready, 1);
      hs_lat_fix = 0;
      seen = 0;
      repeat (20) begin @(posedge clk); #2; seen |= res_valid; end
      check("abort_no_result", seen, 0);

      // abort while a result is being held
      hold_low = 1;
      issue(7, 6, tgt_lo, 0); wait_rv();
      abort = 1; @(posedge clk); #1; abort = 0;
      check("abort_report_rv", res_valid, 0);
      check("abort_report_busy", busy, 0);
      #1; hold_low = 0;
      repeat (3) @(posedge clk);

      hs_mode = 1;
      for (int i = 0; i < 14; i++) begin
         salt = $urandom; s = $urandom; len = $urandom_range(0, 6);
         if (s > 32'hffff_fff0) s = s - 32'h10;
         if (i % 5 == 4) begin s = s | 32'h1; en = s - 1; end
         else en = s + len;
         kk = $urandom_range(0, len + 2);
         if (kk <= len)  tgt = hash_of(32'(s + kk));
         else if (i % 2) tgt = '0;
         else            tgt = {$urandom, 224'h0};
         issue(s, en, tgt, 1); wait_done("rand");
      end

      // async reset in the middle of a long sweep
      hs_mode = 0; hit_n = 32'hffffffff;
      issue(0, 200, tgt_lo, 0);
      repeat (12) @(posedge clk); #3; rst = 1; #1;
      check("rst_flags", {job_ready, busy, hash_enable, res_valid, res_found, res_err}, 0);
      check("rst_nonce", nonce, 0);
      check("rst_block", block[0:255], 0);
      check("rst_target", target, 0);
      check("rst_res", {res_nonce, res_count}, 0);
      check("rst_res_hash", res_hash, 0);
      repeat (2) @(posedge clk); #3; rst = 0; #1;
      check("rel_ready_before_clk", job_ready, 0);
      @(posedge clk); #1;
      check("rel_ready_after_clk", job_ready, 1);
      repeat (10) @(posedge clk);
      hit_n = 32'h15;
      issue(32'h14, 32'h16, tgt_lo, 1); wait_done("recover");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
